// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the two-requester write-port arbiter: default widths,
// output-register state encoding, requester-ID type and the winner function.
package wb_port_arbiter_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // Width of the data mux slice block.
    localparam int MUX_W = 32;

    // Output register occupancy.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // Requester identifier (two requesters).
    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

    // Winner selection: a lone requester always wins; on a tie the requester
    // that was not granted last wins, unless fixed priority forces requester 0.
    function automatic req_id_t pick_winner(
        input logic    v0,
        input logic    v1,
        input req_id_t last,
        input logic    fixed
    );
        req_id_t w;
        w = REQ0;
        if (v0 && v1) begin
            w = fixed ? REQ0 : ~last;
        end else if (v1) begin
            w = REQ1;
        end
        return w;
    endfunction

endpackage

// File: rtl/MUX21_32.sv
// 32-bit 2:1 multiplexer: sel_i=0 passes a_i, sel_i=1 passes b_i.
module MUX21_32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        sel_i,
    output logic [31:0] y_o
);

    // Pure combinational select.
    always_comb begin
        y_o = sel_i ? b_i : a_i;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Two-requester write-port arbiter feeding a single registered output slot.
// Round-robin on ties by default; define ARB_FIXED_PRIO_EN to make requester 0
// win every tie. The output slot drains and reloads on the same edge, so a
// continuously ready consumer sees no bubbles.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,

    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,

    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_src,
    input  logic              out_ready
);

`ifdef ARB_FIXED_PRIO_EN
    localparam logic FIXED_PRIO = 1'b1;
`else
    localparam logic FIXED_PRIO = 1'b0;
`endif

    // The data path is built from 32-bit mux slices; inputs are zero-padded
    // up to a whole number of slices and the result is cut back to DATA_W.
    localparam int NSLICE = (DATA_W + MUX_W - 1) / MUX_W;
    localparam int PAD_W  = NSLICE * MUX_W;

    out_state_e        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    req_id_t           src_q, src_d;
    req_id_t           last_grant_q, last_grant_d;

    req_id_t           winner;
    logic              any_valid;
    logic              can_accept;
    logic              transfer;
    logic [PAD_W-1:0]  mux_a, mux_b, mux_y;
    logic [ADDR_W-1:0] win_addr;

    // Arbitration and acceptance; nothing is accepted while reset is held.
    always_comb begin
        any_valid  = req0_valid | req1_valid;
        winner     = pick_winner(req0_valid, req1_valid, last_grant_q, FIXED_PRIO);
        can_accept = (state_q == ST_EMPTY) | out_ready;
        transfer   = rst_n & can_accept & any_valid;
    end

    // Zero-pad requester payloads to the slice-aligned width.
    always_comb begin
        mux_a              = '0;
        mux_b              = '0;
        mux_a[DATA_W-1:0]  = req0_data;
        mux_b[DATA_W-1:0]  = req1_data;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NSLICE; gi++) begin : g_data_mux
            MUX21_32 u_mux (
                .a_i   (mux_a[gi*MUX_W +: MUX_W]),
                .b_i   (mux_b[gi*MUX_W +: MUX_W]),
                .sel_i (winner),
                .y_o   (mux_y[gi*MUX_W +: MUX_W])
            );
        end
    endgenerate

    assign win_addr = (winner == REQ1) ? req1_addr : req0_addr;

    // State and held-write registers; reset discards any held write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            data_q       <= '0;
            addr_q       <= '0;
            src_q        <= REQ0;
            last_grant_q <= REQ1;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            addr_q       <= addr_d;
            src_q        <= src_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next state: load on transfer (also when draining), empty on a drain alone.
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        addr_d       = addr_q;
        src_d        = src_q;
        last_grant_d = last_grant_q;
        if (transfer) begin
            state_d      = ST_FULL;
            data_d       = mux_y[DATA_W-1:0];
            addr_d       = win_addr;
            src_d        = winner;
            last_grant_d = winner;
        end else if ((state_q == ST_FULL) && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // Outputs: handshake readies go only to the winning requester.
    always_comb begin
        out_valid  = (state_q == ST_FULL);
        req0_ready = transfer & (winner == REQ0);
        req1_ready = transfer & (winner == REQ1);
    end

    assign out_data = data_q;
    assign out_addr = addr_q;
    assign out_src  = src_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus a random
// run checked against a scoreboard of accepted writes.
module tb_wb_port_arbiter;

`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_data, req1_data;
    logic [4:0]  req0_addr, req1_addr;
    logic        req0_ready, req1_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [4:0]  out_addr;
    logic        out_src;
    logic        out_ready;

    int tests_run = 0;
    int fails     = 0;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  a;
        logic        s;
    } wr_t;

    wr_t sb[$];

    wb_port_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_addr  (req0_addr),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_addr  (req1_addr),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_src    (out_src),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v0, input logic [31:0] d0, input logic [4:0] a0,
                         input logic v1, input logic [31:0] d1, input logic [4:0] a1,
                         input logic ordy);
        req0_valid = v0; req0_data = d0; req0_addr = a0;
        req1_valid = v1; req1_data = d1; req1_addr = a1;
        out_ready  = ordy;
    endtask

    // Pulse reset, ending at a falling edge with reset released.
    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, 32'hFFFF_FFFF, 5'h1F, 1, 32'hEEEE_EEEE, 5'h1E, 1);
        @(negedge clk);
        tests_run++;
        if ({out_valid, out_data, out_addr, out_src} !== 39'd0) begin
            fails++;
            $display("FAIL reset_out: got v=%0b d=%h a=%h s=%0b want all zero",
                     out_valid, out_data, out_addr, out_src);
        end
        tests_run++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            fails++;
            $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
        end
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: out_valid got %0b want 0", out_valid);
        end
        $display("[TB] reset: outputs cleared, readies low");
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        do_reset();
        drive(1, 32'hDEAD_BEEF, 5'd3, 0, 0, 0, 1);
        #1;
        tests_run++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            fails++;
            $display("FAIL single_ready: got %b%b want 10", req0_ready, req1_ready);
        end
        @(negedge clk);
        tests_run++;
        if ({out_valid, out_data, out_addr, out_src} !== {1'b1, 32'hDEAD_BEEF, 5'd3, 1'b0}) begin
            fails++;
            $display("FAIL single_out: got v=%0b d=%h a=%0d s=%0b want v=1 d=deadbeef a=3 s=0",
                     out_valid, out_data, out_addr, out_src);
        end
        $display("[TB] single: d=%h a=%0d s=%0b", out_data, out_addr, out_src);
        drive(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_drain: out_valid got %0b want 0", out_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] d0, d1;
        logic        exp_w;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            d0 = 32'hA000_0000 + i;
            d1 = 32'hB000_0000 + i;
            exp_w = FIXED ? 1'b0 : i[0];
            drive(1, d0, 5'(i), 1, d1, 5'(i + 8), 1);
            #1;
            tests_run++;
            if ({req0_ready, req1_ready} !== {~exp_w, exp_w}) begin
                fails++;
                $display("FAIL rr_ready[%0d]: got %b%b want %b%b", i, req0_ready, req1_ready,
                         ~exp_w, exp_w);
            end
            @(negedge clk);
            tests_run++;
            if ({out_valid, out_src, out_data} !== {1'b1, exp_w, (exp_w ? d1 : d0)}) begin
                fails++;
                $display("FAIL rr_out[%0d]: got v=%0b s=%0b d=%h want v=1 s=%0b d=%h", i,
                         out_valid, out_src, out_data, exp_w, exp_w ? d1 : d0);
            end
            $display("[TB] tie %0d: grant=%0b d=%h", i, out_src, out_data);
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic exp_w;
        do_reset();
        drive(1, 32'h11, 5'd1, 0, 0, 0, 0);
        #1;
        tests_run++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            fails++;
            $display("FAIL bp_load_ready: got %b%b want 10", req0_ready, req1_ready);
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h22, 5'd2, 1, 32'h33, 5'd3, 0);
            #1;
            tests_run++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                fails++;
                $display("FAIL bp_stall_ready[%0d]: got %b%b want 00", i, req0_ready, req1_ready);
            end
            @(negedge clk);
            tests_run++;
            if ({out_valid, out_data, out_addr, out_src} !== {1'b1, 32'h11, 5'd1, 1'b0}) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got v=%0b d=%h a=%0d s=%0b want v=1 d=11 a=1 s=0",
                         i, out_valid, out_data, out_addr, out_src);
            end
            $display("[TB] stall %0d: held d=%h", i, out_data);
        end
        exp_w = FIXED ? 1'b0 : 1'b1;
        drive(1, 32'h22, 5'd2, 1, 32'h33, 5'd3, 1);
        #1;
        tests_run++;
        if ({req0_ready, req1_ready} !== {~exp_w, exp_w}) begin
            fails++;
            $display("FAIL bp_release_ready: got %b%b want %b%b", req0_ready, req1_ready,
                     ~exp_w, exp_w);
        end
        @(negedge clk);
        tests_run++;
        if ({out_valid, out_src, out_data} !== {1'b1, exp_w, (exp_w ? 32'h33 : 32'h22)}) begin
            fails++;
            $display("FAIL bp_reload: got v=%0b s=%0b d=%h want v=1 s=%0b", out_valid, out_src,
                     out_data, exp_w);
        end
        $display("[TB] release: drain+load d=%h s=%0b", out_data, out_src);
        drive(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        do_reset();
        drive(0, 0, 0, 1, 32'h1234_5678, 5'd7, 0);
        #1;
        tests_run++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            fails++;
            $display("FAIL mid_load_ready: got %b%b want 01", req0_ready, req1_ready);
        end
        @(negedge clk);
        tests_run++;
        if ({out_valid, out_data} !== {1'b1, 32'h1234_5678}) begin
            fails++;
            $display("FAIL mid_full: got v=%0b d=%h want v=1 d=12345678", out_valid, out_data);
        end
        drive(1, 32'h5555_5555, 5'd1, 1, 32'h6666_6666, 5'd2, 0);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, out_data, out_addr, out_src} !== 39'd0) begin
            fails++;
            $display("FAIL mid_async_clear: got v=%0b d=%h a=%0d s=%0b want all zero",
                     out_valid, out_data, out_addr, out_src);
        end
        tests_run++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            fails++;
            $display("FAIL mid_reset_ready: got %b%b want 00", req0_ready, req1_ready);
        end
        $display("[TB] async reset while full: v=%0b d=%h", out_valid, out_data);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 32'hCAFE_0000, 5'd4, 1, 32'hCAFE_0001, 5'd5, 1);
        #1;
        tests_run++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            fails++;
            $display("FAIL mid_first_tie: got %b%b want 10", req0_ready, req1_ready);
        end
        @(negedge clk);
        tests_run++;
        if ({out_valid, out_src, out_data, out_addr} !== {1'b1, 1'b0, 32'hCAFE_0000, 5'd4}) begin
            fails++;
            $display("FAIL mid_after_release: got v=%0b s=%0b d=%h a=%0d want v=1 s=0 d=cafe0000 a=4",
                     out_valid, out_src, out_data, out_addr);
        end
        $display("[TB] after release: first tie s=%0b d=%h", out_src, out_data);
        drive(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
    endtask

    task automatic test_random();
        logic        m_full, m_lg;
        logic        v0, v1, ordy, win, xfer, e_r0, e_r1;
        logic [31:0] d0, d1;
        logic [4:0]  a0, a1;
        wr_t         e;
        wr_t         n;
        int          accepted, emitted;
        accepted = 0;
        emitted  = 0;
        sb.delete();
        do_reset();
        m_full = 1'b0;
        m_lg   = 1'b1;
        for (int c = 0; c < 10000 + 8; c++) begin
            if (c < 10000) begin
                v0   = 1'($urandom_range(0, 1));
                v1   = 1'($urandom_range(0, 1));
                ordy = ($urandom_range(0, 3) != 0);
            end else begin
                v0   = 1'b0;
                v1   = 1'b0;
                ordy = 1'b1;
            end
            d0 = $urandom;
            d1 = $urandom;
            a0 = 5'($urandom_range(0, 31));
            a1 = 5'($urandom_range(0, 31));
            tests_run++;
            if (out_valid !== m_full) begin
                fails++;
                $display("FAIL rnd_valid@%0d: got %0b want %0b", c, out_valid, m_full);
            end
            if (m_full && ordy) begin
                tests_run++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL rnd_underflow@%0d: got d=%h want no write", c, out_data);
                end else begin
                    e = sb.pop_front();
                    emitted++;
                    if ({out_data, out_addr, out_src} !== {e.d, e.a, e.s}) begin
                        fails++;
                        $display("FAIL rnd_write@%0d: got d=%h a=%0d s=%0b want d=%h a=%0d s=%0b",
                                 c, out_data, out_addr, out_src, e.d, e.a, e.s);
                    end
                    $display("[TB] emit %0d: d=%h a=%0d s=%0b", emitted, out_data, out_addr, out_src);
                end
            end
            drive(v0, d0, a0, v1, d1, a1, ordy);
            if (v0 && v1) win = FIXED ? 1'b0 : ~m_lg;
            else if (v1)  win = 1'b1;
            else          win = 1'b0;
            xfer = (!m_full || ordy) && (v0 || v1);
            e_r0 = xfer && !win;
            e_r1 = xfer && win;
            #1;
            tests_run++;
            if ({req0_ready, req1_ready} !== {e_r0, e_r1}) begin
                fails++;
                $display("FAIL rnd_ready@%0d: got %b%b want %b%b", c, req0_ready, req1_ready,
                         e_r0, e_r1);
            end
            if (xfer) begin
                n.d = win ? d1 : d0;
                n.a = win ? a1 : a0;
                n.s = win;
                sb.push_back(n);
                accepted++;
                m_lg   = win;
                m_full = 1'b1;
            end else if (m_full && ordy) begin
                m_full = 1'b0;
            end
            @(negedge clk);
        end
        tests_run++;
        if (sb.size() != 0 || accepted != emitted) begin
            fails++;
            $display("FAIL rnd_balance: got %0d emitted want %0d accepted (%0d left)",
                     emitted, accepted, sb.size());
        end
        $display("[TB] random: %0d accepted, %0d emitted", accepted, emitted);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
